// File: rtl/serial_endpoint_pkg.sv
// serial_endpoint_pkg
//    Shared types and helpers for the serial endpoint slice.
//    BYTE_W / byte_t : width and type of one serial byte.
//    fifo_op_e       : the four things a FIFO can do on one clock edge.
//    fifo_op()       : packs accepted push/pop strobes into a fifo_op_e.
package serial_endpoint_pkg;

   localparam int BYTE_W = 8;

   typedef logic [BYTE_W-1:0] byte_t;

   // Encoding is {pop, push} so that fifo_op() is a plain concatenation.
   typedef enum logic [1:0] {
      FIFO_HOLD = 2'b00,
      FIFO_PUSH = 2'b01,
      FIFO_POP  = 2'b10,
      FIFO_BOTH = 2'b11
   } fifo_op_e;

   function automatic fifo_op_e fifo_op(input logic push_ok, input logic pop_ok);
      return fifo_op_e'({pop_ok, push_ok});
   endfunction

endpackage

// File: rtl/serial_endpoint_byte_fifo.sv
// byte_fifo
//    First-word-fall-through byte FIFO. The head byte is read combinationally
//    from storage and forced to zero while the FIFO is empty, so the data
//    output is clean after reset. full/empty/count depend on registered state
//    only; push is ignored when full and pop is ignored when empty, both
//    judged on the state before the edge.
// Ports
//    clock      in   rising-edge clock
//    reset      in   synchronous, active-low; empties the FIFO
//    push       in   write strobe
//    push_data  in   byte to write
//    pop        in   read strobe (removes the head)
//    pop_data   out  head byte (0 when empty)
//    count      out  occupancy, 0..DEPTH
//    full       out  count == DEPTH
//    empty      out  count == 0
module byte_fifo
   import serial_endpoint_pkg::*;
#(
   parameter  int DEPTH = 16,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  byte_t            push_data,
   input  logic             pop,
   output byte_t            pop_data,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   byte_t            mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] wr_ptr_next;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_next;
   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] count_next;
   logic             push_ok;
   logic             pop_ok;
   fifo_op_e         op;

   assign full    = (count_reg == CNT_W'(DEPTH));
   assign empty   = (count_reg == '0);
   assign count   = count_reg;

   // Gating by full/empty is what resolves the corner cases: on a full FIFO
   // a simultaneous push is refused, on an empty FIFO a simultaneous pop is.
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign op      = fifo_op(push_ok, pop_ok);

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      count_next  = count_reg;
      case (op)
         FIFO_PUSH: begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            count_next  = count_reg + CNT_W'(1);
         end
         FIFO_POP: begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            count_next  = count_reg - CNT_W'(1);
         end
         FIFO_BOTH: begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         count_reg  <= count_next;
      end
   end

   // Storage has no reset; the counters alone decide which entries are live.
   always_ff @(posedge clock) begin
      if (reset && push_ok) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_comb begin
      pop_data = '0;
      if (!empty) begin
         pop_data = mem[rd_ptr_reg];
      end
   end

endmodule

// File: rtl/serial_endpoint.sv
// serial_endpoint
//    Far-end responder for the processor's byte-serial port. The RX FIFO
//    carries bytes host -> processor, the TX FIFO processor -> host. Both host
//    sides are valid/ready byte streams; the processor side matches its
//    serial_* ports directly.
// Ports
//    clock, reset            rising-edge clock, synchronous active-low reset
//    cpu_rx_data_out/valid   RX head and non-empty flag toward the processor
//    cpu_rden_in             processor pops the RX head
//    cpu_tx_ready_out        TX not full
//    cpu_tx_data_in/wren_in  processor pushes a byte into TX
//    host_in_data/valid      host byte into RX; host_in_ready = RX not full
//    host_out_data/valid     TX head toward host; host_out_ready pops it
//    rx_count_out/tx_count_out  FIFO occupancy
// Optional (macro SERIAL_ENDPOINT_OVF_EN)
//    ovf_clr_in   clears both sticky flags
//    rx_ovf_out   sticky: processor read while RX was empty
//    tx_ovf_out   sticky: processor wrote while TX was full
//    Without the macro those ports do not exist and the events are ignored.
module serial_endpoint
   import serial_endpoint_pkg::*;
#(
   parameter  int DEPTH = 16,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clock,
   input  logic             reset,
   output byte_t            cpu_rx_data_out,
   output logic             cpu_rx_valid_out,
   input  logic             cpu_rden_in,
   output logic             cpu_tx_ready_out,
   input  byte_t            cpu_tx_data_in,
   input  logic             cpu_wren_in,
   input  byte_t            host_in_data,
   input  logic             host_in_valid,
   output logic             host_in_ready,
   output byte_t            host_out_data,
   output logic             host_out_valid,
   input  logic             host_out_ready,
   output logic [CNT_W-1:0] rx_count_out,
   output logic [CNT_W-1:0] tx_count_out
`ifdef SERIAL_ENDPOINT_OVF_EN
   ,
   input  logic             ovf_clr_in,
   output logic             rx_ovf_out,
   output logic             tx_ovf_out
`endif
);

   logic rx_full;
   logic rx_empty;
   logic tx_full;
   logic tx_empty;

   byte_fifo #(.DEPTH(DEPTH)) rx_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (host_in_valid),
      .push_data (host_in_data),
      .pop       (cpu_rden_in),
      .pop_data  (cpu_rx_data_out),
      .count     (rx_count_out),
      .full      (rx_full),
      .empty     (rx_empty)
   );

   byte_fifo #(.DEPTH(DEPTH)) tx_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (cpu_wren_in),
      .push_data (cpu_tx_data_in),
      .pop       (host_out_ready),
      .pop_data  (host_out_data),
      .count     (tx_count_out),
      .full      (tx_full),
      .empty     (tx_empty)
   );

   assign host_in_ready    = ~rx_full;
   assign cpu_rx_valid_out = ~rx_empty;
   assign cpu_tx_ready_out = ~tx_full;
   assign host_out_valid   = ~tx_empty;

`ifdef SERIAL_ENDPOINT_OVF_EN
   logic rx_ovf_reg;
   logic tx_ovf_reg;

   // A new error event in the same cycle as a clear leaves the flag set, so
   // software never loses an event that raced with its own clear.
   always_ff @(posedge clock) begin
      if (!reset) begin
         rx_ovf_reg <= 1'b0;
         tx_ovf_reg <= 1'b0;
      end else begin
         if (cpu_rden_in && rx_empty) begin
            rx_ovf_reg <= 1'b1;
         end else if (ovf_clr_in) begin
            rx_ovf_reg <= 1'b0;
         end
         if (cpu_wren_in && tx_full) begin
            tx_ovf_reg <= 1'b1;
         end else if (ovf_clr_in) begin
            tx_ovf_reg <= 1'b0;
         end
      end
   end

   assign rx_ovf_out = rx_ovf_reg;
   assign tx_ovf_out = tx_ovf_reg;
`endif

endmodule
